// File: rtl/spi_master_ctrl.sv
// SPI master that turns host write/read requests into two-frame command
// sequences (address frame, then data frame) toward the SPI slave RAM wrapper.
`timescale 1ns/1ps
module spi_master_ctrl #(
  parameter int unsigned MEM_DEPTH  = 256,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned GAP_CYCLES = 1,
  localparam int unsigned ADDR_SIZE = $clog2(MEM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [ADDR_SIZE-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [ADDR_SIZE-1:0] rsp_rdata,
  output logic                 busy,
  output logic                 SS_n,
  output logic                 MOSI,
  input  logic                 MISO
);

  localparam int unsigned FRAME_W = ADDR_SIZE + 2;
  localparam int unsigned MAX_A   = (FRAME_W > RD_LAT) ? FRAME_W : RD_LAT;
  localparam int unsigned CNT_MAX = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_SHIFT, S_HOLD, S_WAIT, S_RECV, S_GAP, S_DONE
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic                 phase, phase_nxt;      // 0 = address frame, 1 = data frame
  logic                 op_we, op_we_nxt;
  logic [ADDR_SIZE-1:0] op_addr, op_addr_nxt;
  logic [ADDR_SIZE-1:0] op_wdata, op_wdata_nxt;
  logic [FRAME_W-1:0]   tx, tx_nxt;
  logic [ADDR_SIZE-1:0] rx, rx_nxt;
  logic [ADDR_SIZE-1:0] payload;
  logic                 accept;
  logic                 ss_n_nxt, mosi_nxt, ready_nxt, rsp_valid_nxt;
  logic [ADDR_SIZE-1:0] rsp_rdata_nxt;

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      phase     <= 1'b0;
      op_we     <= 1'b0;
      op_addr   <= '0;
      op_wdata  <= '0;
      tx        <= '0;
      rx        <= '0;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      phase     <= phase_nxt;
      op_we     <= op_we_nxt;
      op_addr   <= op_addr_nxt;
      op_wdata  <= op_wdata_nxt;
      tx        <= tx_nxt;
      rx        <= rx_nxt;
      SS_n      <= ss_n_nxt;
      MOSI      <= mosi_nxt;
      req_ready <= ready_nxt;
      busy      <= ~ready_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
    end
  end

  // Next-state, counter, shift registers and output decode of the next state
  always_comb begin
    state_nxt     = state;
    phase_nxt     = phase;
    op_we_nxt     = op_we;
    op_addr_nxt   = op_addr;
    op_wdata_nxt  = op_wdata;
    tx_nxt        = tx;
    rx_nxt        = rx;
    ss_n_nxt      = 1'b1;
    mosi_nxt      = 1'b0;
    ready_nxt     = 1'b0;
    rsp_valid_nxt = 1'b0;
    rsp_rdata_nxt = rsp_rdata;
    payload       = op_we ? op_wdata : '0;
    accept        = req_valid && req_ready;

    case (state)
      S_IDLE:  if (accept) state_nxt = S_START;
      S_START: state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (cnt == CNT_W'(FRAME_W - 1)) begin
          if (phase && !op_we) state_nxt = (RD_LAT == 0) ? S_RECV : S_WAIT;
          else                 state_nxt = S_HOLD;
        end
      end
      S_HOLD:  state_nxt = S_GAP;
      S_WAIT:  if (cnt == CNT_W'(RD_LAT - 1)) state_nxt = S_RECV;
      S_RECV:  if (cnt == CNT_W'(ADDR_SIZE - 1)) state_nxt = S_GAP;
      S_GAP:   if (cnt == CNT_W'(GAP_CYCLES - 1)) state_nxt = phase ? S_DONE : S_START;
      S_DONE:  state_nxt = accept ? S_START : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    if (accept) begin
      op_we_nxt    = req_we;
      op_addr_nxt  = req_addr;
      op_wdata_nxt = req_wdata;
    end

    // Counter restarts on every state change and rests at zero in IDLE
    cnt_nxt = (state_nxt != state || state_nxt == S_IDLE) ? '0 : cnt + CNT_W'(1);

    // Shift MISO in only while receiving
    if (state == S_RECV) rx_nxt = ADDR_SIZE'({rx, MISO});

    case (state_nxt)
      S_IDLE:  ready_nxt = 1'b1;
      S_START: begin
        ss_n_nxt  = 1'b0;
        phase_nxt = ~accept;
        tx_nxt    = accept ? {~req_we, 1'b0, req_addr} : {~op_we, 1'b1, payload};
        mosi_nxt  = tx_nxt[FRAME_W-1];
      end
      S_SHIFT: begin
        ss_n_nxt = 1'b0;
        mosi_nxt = tx[FRAME_W-1];
        tx_nxt   = {tx[FRAME_W-2:0], 1'b0};
      end
      S_HOLD, S_WAIT, S_RECV: ss_n_nxt = 1'b0;
      S_DONE: begin
        ready_nxt     = 1'b1;
        rsp_valid_nxt = 1'b1;
        rsp_rdata_nxt = op_we ? '0 : rx;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Randomized and directed bench for spi_master_ctrl against a cycle-list model.
`timescale 1ns/1ps
module tb_spi_master_ctrl;

  localparam int unsigned AW  = 8;
  localparam int unsigned RDL = 2;
  localparam int unsigned GAP = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr, req_wdata, rsp_rdata;
  logic          rsp_valid, busy, SS_n, MOSI, MISO;

  spi_master_ctrl #(.MEM_DEPTH(256), .RD_LAT(RDL), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [AW-1:0] wdata;
    logic [AW-1:0] rdval;
  } op_t;

  // Expected per-cycle line values plus what the model slave drives on MISO
  typedef struct packed {
    logic ss_n, mosi, rsp, ready, miso_en, miso;
  } cyc_t;

  int            n_tests = 0;
  int            n_fail  = 0;
  cyc_t          exp_q[$];
  op_t           ops[$];
  bit            b2b;
  int            junk_at;
  logic [AW-1:0] last_rdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic void push(bit ss, bit m, bit rsp, bit rdy, bit men, bit mv);
    cyc_t c;
    c = '{ss_n: ss, mosi: m, rsp: rsp, ready: rdy, miso_en: men, miso: mv};
    exp_q.push_back(c);
  endfunction

  // One frame: selector bit, 10-bit word MSB first, then hold or wait+receive, then gap
  function automatic void add_frame(logic [1:0] cmd, logic [AW-1:0] pl, bit rd_data,
                                    logic [AW-1:0] rdval);
    logic [AW+1:0] word;
    word = {cmd, pl};
    push(0, cmd[1], 0, 0, 0, 0);
    for (int i = AW + 1; i >= 0; i--) push(0, word[i], 0, 0, 0, 0);
    if (rd_data) begin
      for (int i = 0; i < RDL; i++) push(0, 0, 0, 0, 0, 0);
      for (int i = AW - 1; i >= 0; i--) push(0, 0, 0, 0, 1, rdval[i]);
    end else begin
      push(0, 0, 0, 0, 0, 0);
    end
    for (int i = 0; i < GAP; i++) push(1, 0, 0, 0, 0, 0);
  endfunction

  function automatic void build_expect(op_t o);
    exp_q.delete();
    if (o.we) begin
      add_frame(2'b00, o.addr, 0, '0);
      add_frame(2'b01, o.wdata, 0, '0);
    end else begin
      add_frame(2'b10, o.addr, 0, '0);
      add_frame(2'b11, '0, 1, o.rdval);
    end
    push(1, 0, 1, 1, 0, 0);
  endfunction

  function automatic op_t mk_op(logic we, logic [AW-1:0] a, logic [AW-1:0] d, logic [AW-1:0] r);
    op_t o;
    o = '{we: we, addr: a, wdata: d, rdval: r};
    return o;
  endfunction

  task automatic drive_req(op_t o);
    req_valid = 1'b1;
    req_we    = o.we;
    req_addr  = o.addr;
    req_wdata = o.wdata;
  endtask

  // Runs the ops queue; b2b keeps req_valid high so each next op is taken in DONE
  task automatic run_ops();
    for (int k = 0; k < ops.size(); k++) begin
      if (k == 0 || !b2b) begin
        @(negedge clk);
        chk($sformatf("ready_before_op%0d", k), req_ready, 1);
        drive_req(ops[k]);
      end
      build_expect(ops[k]);
      for (int n = 1; n <= exp_q.size(); n++) begin
        cyc_t e;
        e = exp_q[n-1];
        @(negedge clk);
        chk($sformatf("op%0d_cyc%0d", k, n), {SS_n, MOSI, rsp_valid, req_ready, busy},
            {e.ss_n, e.mosi, e.rsp, e.ready, ~e.ready});
        if (e.rsp) begin
          last_rdata = ops[k].we ? '0 : ops[k].rdval;
          chk($sformatf("op%0d_rdata", k), rsp_rdata, last_rdata);
        end
        if (n == 1) begin
          if (b2b && k + 1 < ops.size()) drive_req(ops[k+1]);
          else req_valid = 1'b0;
        end
        if (n == junk_at) begin
          req_valid = 1'b1;
          req_we    = 1'($urandom);
          req_addr  = AW'($urandom);
          req_wdata = AW'($urandom);
        end
        if (n == junk_at + 1) req_valid = 1'b0;
        MISO = e.miso_en ? e.miso : 1'($urandom);
      end
    end
    @(negedge clk);
    chk("idle_lines", {SS_n, MOSI, rsp_valid, req_ready, busy}, 5'b10010);
    chk("rdata_hold", rsp_rdata, last_rdata);
  endtask

  task automatic run_one(op_t o, int junk);
    ops.delete();
    ops.push_back(o);
    b2b     = 1'b0;
    junk_at = junk;
    run_ops();
  endtask

  // Reset asserted in the 5th SHIFT bit of the write-data frame (cycle 19)
  task automatic reset_test();
    int lows, pulses;
    op_t o;
    o = mk_op(1'b1, 8'h3C, 8'hA5, 8'h00);
    build_expect(o);
    @(negedge clk);
    drive_req(o);
    for (int n = 1; n <= 19; n++) begin
      cyc_t e;
      e = exp_q[n-1];
      @(negedge clk);
      chk($sformatf("rst_op_cyc%0d", n), {SS_n, MOSI, rsp_valid, req_ready, busy},
          {e.ss_n, e.mosi, e.rsp, e.ready, ~e.ready});
      if (n == 1) req_valid = 1'b0;
      MISO = 1'($urandom);
    end
    rst       = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 8'h55;
    @(negedge clk);
    chk("rst_mid_lines", {SS_n, MOSI, rsp_valid, req_ready, busy}, 5'b10010);
    chk("rst_mid_rdata", rsp_rdata, 0);
    rst        = 1'b0;
    req_valid  = 1'b0;
    last_rdata = '0;
    lows   = 0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (!SS_n) lows++;
      if (rsp_valid) pulses++;
      MISO = 1'($urandom);
    end
    chk("rst_no_rsp", pulses, 0);
    chk("rst_ss_idle", lows, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    MISO       = 1'b0;
    last_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_lines", {SS_n, MOSI, rsp_valid, req_ready, busy}, 5'b10010);
    chk("reset_rdata", rsp_rdata, 0);
    rst = 1'b0;

    // Basic write and read of the same location
    run_one(mk_op(1'b1, 8'h3C, 8'hA5, 8'h00), -5);
    run_one(mk_op(1'b0, 8'h3C, 8'h00, 8'hA5), -5);

    // Back-to-back write then read with req_valid held high
    ops.delete();
    ops.push_back(mk_op(1'b1, 8'h12, 8'h34, 8'h00));
    ops.push_back(mk_op(1'b0, 8'h12, 8'h00, 8'h34));
    b2b     = 1'b1;
    junk_at = -5;
    run_ops();

    // Requests pulsed while busy must not disturb the stream
    run_one(mk_op(1'b1, 8'h5A, 8'hC3, 8'h00), 5);
    run_one(mk_op(1'b0, 8'h81, 8'h00, 8'h7E), 20);

    // Boundary payloads
    run_one(mk_op(1'b1, 8'h00, 8'hFF, 8'h00), -5);
    run_one(mk_op(1'b1, 8'hFF, 8'hFF, 8'h00), -5);
    run_one(mk_op(1'b1, 8'hFF, 8'h00, 8'h00), -5);
    run_one(mk_op(1'b0, 8'h00, 8'h00, 8'hFF), -5);
    run_one(mk_op(1'b0, 8'hFF, 8'h00, 8'hFF), -5);
    run_one(mk_op(1'b0, 8'hFF, 8'h00, 8'h00), -5);

    reset_test();

    // Randomized groups, alternating isolated and back-to-back
    for (int g = 0; g < 6; g++) begin
      ops.delete();
      for (int i = 0; i < 5; i++)
        ops.push_back(mk_op(1'($urandom), AW'($urandom), AW'($urandom), AW'($urandom)));
      b2b     = g[0];
      junk_at = b2b ? -5 : 2 + int'($urandom_range(0, 20));
      run_ops();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Host-side SPI master that sequences memory transactions into the SPI slave + RAM wrapper over SS_n/MOSI/MISO.
- Accepts one write or read request at a time on a valid/ready port.
- Issues the required command frames: write = address frame + data frame; read = address frame + data frame with MISO capture.
- Returns a completion pulse, carrying read data on reads.

Parameters:
- MEM_DEPTH, 256, RAM depth; ADDR_SIZE = $clog2(MEM_DEPTH) sets the payload width; frame word = ADDR_SIZE+2 bits.
- RD_LAT, 2, SS_n-low dead cycles between the last MOSI bit of a read-data frame and the first MISO sample.
- GAP_CYCLES, 1, minimum SS_n-high cycles between frames (value ≥1).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  host request valid.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_SIZE  memory address.
- req_wdata  in  ADDR_SIZE  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  ADDR_SIZE  read data, valid with rsp_valid; 0 on writes.
- busy  out  1  transaction in progress (equals !req_ready).
- SS_n  out  1  slave select, active-low.
- MOSI  out  1  serial data to slave.
- MISO  in  1  serial data from slave.

Behaviour:
- Reset values: SS_n=1, MOSI=0, req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, FSM=IDLE, all counters 0.
- Accept: a request is taken on a cycle with req_valid && req_ready.
  - req_we, req_addr and req_wdata are registered on that cycle.
  - req_ready drops the next cycle.
  - Request inputs are ignored while busy.
- Commands: 00 = write address, 01 = write data, 10 = read address, 11 = read data.
  - Write op = frame(00,addr), then frame(01,wdata).
  - Read op = frame(10,addr), then frame(11,0) with capture.
- FSM states: IDLE -> START -> SHIFT -> HOLD | WAIT -> RECV -> GAP -> START (second frame) or DONE -> IDLE.
- START (1 cycle): SS_n=0, MOSI=cmd[1] (slave command-select bit).
- SHIFT (ADDR_SIZE+2 = 10 cycles): SS_n=0; MOSI = {cmd, payload}, MSB first, one bit per cycle.
- HOLD (1 cycle, address frames and write-data frame): SS_n=0, MOSI=0.
  - Total SS_n-low for these frames = 12 cycles. Slave rx_valid is then expected on the following cycle.
- WAIT (RD_LAT cycles, read-data frame only): SS_n=0, MOSI=0.
- RECV (ADDR_SIZE cycles): SS_n=0; MISO sampled each posedge into a shift register, MSB first.
- GAP (GAP_CYCLES): SS_n=1, MOSI=0.
- DONE (1 cycle): rsp_valid=1.
  - rsp_rdata = captured byte on reads, 0 on writes; rsp_rdata holds its value until the next DONE.
  - req_ready returns to 1 in the same cycle.
- Latency, accept edge to rsp_valid, default parameters:
  - Write: 12 + 1 + 12 + 1 + 1 = 27 cycles.
  - Read: 12 + 1 + (1 + 10 + 2 + 8) + 1 + 1 = 36 cycles.
- Back-to-back: req_valid held high in the DONE cycle is accepted there. The next START follows one cycle later, so SS_n stays high ≥ GAP_CYCLES + 1 between operations.
- Counters: one bit counter sized for max(ADDR_SIZE+2, RD_LAT, ADDR_SIZE, GAP_CYCLES). It clears on every state entry and never wraps within a state.
- Reset mid-operation: the next edge forces all reset values, including SS_n=1. The partial frame is abandoned and no rsp_valid is issued.
- Reset has priority over a simultaneous req_valid.
- MISO is ignored outside RECV.

Test Plan:
- Write addr=0x3C, data=0xA5 after reset.
  - MOSI frame 1 = 0,00_00111100 (selector, then 10 bits); frame 2 = 0,01_10100101.
  - SS_n low 12 cycles each, 1-cycle gap.
  - rsp_valid pulses at cycle 27 with rsp_rdata=0.
- Read addr=0x3C with the model slave returning 0xA5.
  - MOSI frames 1,10_00111100 and 1,11_00000000.
  - MISO sampled on cycles 3..10 after the read-data frame's SHIFT ends.
  - rsp_rdata=0xA5 at cycle 36.
- Back-to-back write then read, req_valid held high: second accept occurs in the first DONE cycle; SS_n is high exactly 2 cycles between the operations.
- Assert rst during the 5th SHIFT bit of a write-data frame: next cycle SS_n=1, MOSI=0, req_ready=1; no rsp_valid.
- req_valid pulsed while busy with different addr/data: it is ignored and the MOSI stream matches the original request.
- Boundary addresses 0x00 and 0xFF, data 0xFF: all-ones and all-zeros payloads shift correctly, and rsp_rdata=0xFF on read-back.
